// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED PIO write arbiter.
package led_arb_pkg;

  typedef enum logic [1:0] {IDLE, ARB, WRITE, GAP} state_t;

  localparam logic [1:0] PIO_LED_ADDR = 2'd0;
  localparam int         LED_W_DEF    = 26;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: returns the first set request after last_grant_i (wrapping),
// plus a valid flag when any request is set. Purely combinational.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_grant_i,
  output logic [IW-1:0]   grant_o,
  output logic            valid_o
);

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (int'(last_grant_i) + k) % NREQ;
      if (!valid_o && req_i[j]) begin
        valid_o = 1'b1;
        grant_o = IW'(j);
      end
    end
  end

endmodule

// File: rtl/led_pio_write_arbiter.sv
// Merges masked LED updates from NREQ requesters into a shadow copy and writes it to PIO s1.
// LED_ARB_PRIO0_EN: requester 0 has fixed priority over the round-robin among the others.
module led_pio_write_arbiter
  import led_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int LED_W      = LED_W_DEF,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LED_W-1:0] req_data,
  input  logic [NREQ*LED_W-1:0] req_mask,
  output logic [NREQ-1:0]       ack,
  output logic [1:0]            pio_address,
  output logic                  pio_chipselect,
  output logic                  pio_write_n,
  output logic [31:0]           pio_writedata,
  output logic [LED_W-1:0]      shadow_out,
  output logic                  busy
);

  localparam int IW = $clog2(NREQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t           state_q, state_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [IW-1:0]    last_q, last_d;
  logic [LED_W-1:0] wdata_q, wdata_d;
  logic [LED_W-1:0] shadow_q, shadow_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic [NREQ-1:0]  arb_req;
  logic [IW-1:0]    rr_grant, pick;
  logic             rr_vld, pick_vld, upd_last;
  logic [LED_W-1:0] data_g, mask_g;

`ifdef LED_ARB_PRIO0_EN
  // Requester 0 is kept out of the rotation so it never moves the pointer.
  assign arb_req  = {req[NREQ-1:1], 1'b0};
  assign pick     = req[0] ? '0 : rr_grant;
  assign pick_vld = req[0] | rr_vld;
  assign upd_last = (grant_q != '0);
`else
  assign arb_req  = req;
  assign pick     = rr_grant;
  assign pick_vld = rr_vld;
  assign upd_last = 1'b1;
`endif

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req_i        (arb_req),
    .last_grant_i (last_q),
    .grant_o      (rr_grant),
    .valid_o      (rr_vld)
  );

  assign data_g = req_data[int'(pick)*LED_W +: LED_W];
  assign mask_g = req_mask[int'(pick)*LED_W +: LED_W];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    wdata_d  = wdata_q;
    shadow_d = shadow_q;
    gap_d    = gap_q;
    case (state_q)
      IDLE: if (|req) state_d = ARB;
      ARB: begin
        if (pick_vld) begin
          grant_d = pick;
          wdata_d = (shadow_q & ~mask_g) | (data_g & mask_g);
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        shadow_d = wdata_q;
        if (upd_last) last_d = grant_q;
        if (GAP_CYCLES > 0) begin
          gap_d   = GW'(GAP_CYCLES - 1);
          state_d = GAP;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // last_q resets to NREQ-1 so the first search after reset begins at index 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= IW'(NREQ - 1);
      wdata_q  <= '0;
      shadow_q <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      wdata_q  <= wdata_d;
      shadow_q <= shadow_d;
      gap_q    <= gap_d;
    end
  end

  // Strobe and ack decode straight from state so an async reset drops them at once.
  assign pio_chipselect = (state_q == WRITE);
  assign pio_write_n    = ~pio_chipselect;
  assign ack            = pio_chipselect ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_q) : '0;
  assign pio_address    = PIO_LED_ADDR;
  assign pio_writedata  = 32'(wdata_q);
  assign shadow_out     = shadow_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_led_pio_write_arbiter.sv
// Scoreboard bench for led_pio_write_arbiter: stimulus queues expected writes, a monitor checks them.
module tb_led_pio_write_arbiter;

  localparam int NREQ = 4;
  localparam int LW   = 26;
  localparam int GAPC = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*LW-1:0] req_data = '0;
  logic [NREQ*LW-1:0] req_mask = '0;
  logic [NREQ-1:0]    ack;
  logic [1:0]         pio_address;
  logic               pio_chipselect, pio_write_n, busy;
  logic [31:0]        pio_writedata;
  logic [LW-1:0]      shadow_out;

  led_pio_write_arbiter #(.NREQ(NREQ), .LED_W(LW), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_mask(req_mask),
    .ack(ack), .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .shadow_out(shadow_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [LW-1:0] val; } exp_t;
  exp_t          q[$];
  logic [LW-1:0] m_shadow = '0;
  int total = 0, bad = 0;
  int cyc = 0, wr_count = 0, exp_period = 0, prev_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [LW-1:0] d, input logic [LW-1:0] m);
    req_data[i*LW +: LW] = d;
    req_mask[i*LW +: LW] = m;
  endtask

  task automatic expect_wr(input int i, input logic [LW-1:0] d, input logic [LW-1:0] m);
    exp_t e;
    m_shadow = (m_shadow & ~m) | (d & m);
    e.idx = i;
    e.val = m_shadow;
    q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    m_shadow = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drops each requester right after its ack, then waits for the block to go idle.
  task automatic wait_clear(input int budget);
    int n;
    logic [NREQ-1:0] pend;
    n = 0;
    while (req != '0 && n < budget) begin
      @(negedge clk);
      pend = ack;
      @(posedge clk);
      #1 req = req & ~pend;
      n++;
    end
    if (req != '0) begin
      total++; bad++;
      $display("FAIL ack_timeout: req still %b after %0d cycles", req, budget);
      req = '0;
    end
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_after_clear", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pio_chipselect && !pio_write_n) begin
          wr_count++;
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write: data %h ack %b, want no write", pio_writedata, ack);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("writedata", pio_writedata, {6'd0, e.val});
            chk("ack_onehot", {28'd0, ack}, 32'd1 << e.idx);
            chk("address", {30'd0, pio_address}, 32'd0);
          end
          if (exp_period != 0 && prev_cyc >= 0)
            chk("write_spacing", cyc - prev_cyc, exp_period);
          prev_cyc = (exp_period != 0) ? cyc : -1;
        end else if (ack != '0) begin
          total++; bad++;
          $display("FAIL ack_without_write: ack %b, want 0", ack);
        end
      end
    end
  end

  initial begin
    int wc;
    #1;
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_cs", {31'd0, pio_chipselect}, 32'd0);
    chk("rst_wn", {31'd0, pio_write_n}, 32'd1);
    chk("rst_wdata", pio_writedata, 32'd0);
    chk("rst_shadow", {6'd0, shadow_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    do_reset();

    // Single masked update with latency check.
    set_slot(1, 26'h3FFFFFF, 26'h00000FF);
    expect_wr(1, 26'h3FFFFFF, 26'h00000FF);
    req[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk("latency_strobe", {31'd0, pio_chipselect}, 32'd1);
    wait_clear(50);
    chk("shadow_t1", {6'd0, shadow_out}, 32'h000000FF);

    // All four together from reset: order 0,1,2,3, period 3+GAP cycles.
    do_reset();
    set_slot(0, 26'h1111111, 26'h000000F);
    set_slot(1, 26'h2222222, 26'h00000F0);
    set_slot(2, 26'h3333333, 26'h0000F00);
    set_slot(3, 26'h0444444, 26'h000F000);
    for (int i = 0; i < 4; i++)
      expect_wr(i, req_data[i*LW +: LW], req_mask[i*LW +: LW]);
    exp_period = 3 + GAPC;
    req = 4'b1111;
    wait_clear(100);
    exp_period = 0;
    chk("shadow_all4", {6'd0, shadow_out}, 32'h00004321);

    // Two sequential masked updates keep each other's bits.
    do_reset();
    set_slot(2, 26'h3FFFFFF, 26'h00000F0);
    expect_wr(2, 26'h3FFFFFF, 26'h00000F0);
    req[2] = 1'b1;
    wait_clear(50);
    set_slot(3, 26'h3FFFFFF, 26'h000000F);
    expect_wr(3, 26'h3FFFFFF, 26'h000000F);
    req[3] = 1'b1;
    wait_clear(50);
    chk("shadow_union", {6'd0, shadow_out}, 32'h000000FF);

    // req[2] raised and withdrawn entirely inside GAP: no write.
    set_slot(0, 26'h0000100, 26'h0000100);
    set_slot(2, 26'h3FFFFFF, 26'h3FFFFFF);
    expect_wr(0, 26'h0000100, 26'h0000100);
    req[0] = 1'b1;
    wc = 0;
    while (ack[0] !== 1'b1 && wc < 50) begin @(negedge clk); wc++; end
    chk("gap_ack0_seen", {31'd0, ack[0]}, 32'd1);
    @(posedge clk);
    #1 req[0] = 1'b0;
    req[2] = 1'b1;
    chk("gap_state_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 req[2] = 1'b0;
    wc = wr_count;
    repeat (10) @(posedge clk);
    #1 chk("gap_no_write", wr_count, wc);
    chk("gap_shadow", {6'd0, shadow_out}, 32'h000001FF);

    // Reset asserted during WRITE: strobe drops immediately, grant lost.
    set_slot(1, 26'h3FFFFFF, 26'h3FFFFFF);
    req[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk("midwr_strobe", {31'd0, pio_chipselect}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midwr_cs", {31'd0, pio_chipselect}, 32'd0);
    chk("midwr_wn", {31'd0, pio_write_n}, 32'd1);
    chk("midwr_ack", {28'd0, ack}, 32'd0);
    chk("midwr_shadow", {6'd0, shadow_out}, 32'd0);
    do_reset();
    set_slot(0, 26'h3FFFFFF, 26'h3000000);
    set_slot(3, 26'h0000AAA, 26'h0000FFF);
    expect_wr(0, 26'h3FFFFFF, 26'h3000000);
    expect_wr(3, 26'h0000AAA, 26'h0000FFF);
    req = 4'b1001;
    wait_clear(100);
    chk("post_rst_shadow", {6'd0, shadow_out}, 32'h03000AAA);

    // req[0] and req[3] held continuously; req[3] uses mask 0.
    set_slot(0, 26'h0000001, 26'h0000003);
    set_slot(3, 26'h3FFFFFF, 26'h0000000);
`ifdef LED_ARB_PRIO0_EN
    for (int k = 0; k < 3; k++) expect_wr(0, 26'h0000001, 26'h0000003);
    expect_wr(3, 26'h3FFFFFF, 26'h0000000);
    req = 4'b1001;
    repeat (13) @(posedge clk);
    #1 req[0] = 1'b0;
    wait_clear(50);
`else
    for (int k = 0; k < 2; k++) begin
      expect_wr(0, 26'h0000001, 26'h0000003);
      expect_wr(3, 26'h3FFFFFF, 26'h0000000);
    end
    req = 4'b1001;
    repeat (18) @(posedge clk);
    #1 req = '0;
    wc = 0;
    while (busy && wc < 50) begin @(negedge clk); wc++; end
`endif
    chk("hold_shadow", {6'd0, shadow_out}, 32'h03000AA9);
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
